// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg : constants and loader state encoding shared by the front end      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_pkg;

    localparam int INSTR_WIDTH       = 32;
    localparam int LOADER_ADDR_WIDTH = 32;
    localparam int BYTE_WIDTH        = 8;
    localparam int WORD_BYTES        = 4;
    localparam int BYTE_CNT_WIDTH    = $clog2(WORD_BYTES);

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader_byte_assembler : big-endian 8-to-32 bit word assembler       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader_byte_assembler
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [BYTE_WIDTH-1:0]  byte_data,
    output logic                   word_valid,
    output logic [INSTR_WIDTH-1:0] word
);

    localparam logic [BYTE_CNT_WIDTH-1:0] CNT_LAST = BYTE_CNT_WIDTH'(WORD_BYTES - 1);
    localparam logic [BYTE_CNT_WIDTH-1:0] CNT_ONE  = BYTE_CNT_WIDTH'(1);

    logic [INSTR_WIDTH-1:0]    shift_q, shift_d;
    logic [BYTE_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // word is the shift register with the current byte already appended, so the
    // caller can latch a complete word on the same edge that samples byte four.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word       = {shift_q[INSTR_WIDTH-BYTE_WIDTH-1:0], byte_data};
        word_valid = byte_valid && !clear && (cnt_q == CNT_LAST);
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = word;
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader : UART byte stream to instruction-memory write port loader   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader
    import mips_pkg::*;
#(
    parameter int                     MEM_DEPTH  = 256,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEFAULT,
    parameter int                     ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [BYTE_WIDTH-1:0]  rx_data,
    input  logic                   rx_valid,
    output logic [INSTR_WIDTH-1:0] instruction_to_write,
    output logic [ADDR_WIDTH-1:0]  address_to_write,
    output logic                   write_enable,
    output logic                   mips_enable,
    output logic                   loading,
    output logic                   load_error,
    output logic [ADDR_WIDTH-1:0]  word_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    loader_state_e          state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  count_q, count_d;
    logic                   we_q, we_d;
    logic                   mips_q, mips_d;
    logic                   loading_q, loading_d;
    logic                   error_q, error_d;

    logic                   asm_valid;
    logic                   asm_word_valid;
    logic [INSTR_WIDTH-1:0] asm_word;

    // The assembler keeps running through the one-cycle WRITE state so a byte
    // arriving right behind a completed word is never dropped.
    assign asm_valid = rx_valid && ((state_q == ST_RECEIVE) || (state_q == ST_WRITE));

    program_loader_byte_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_valid (asm_word_valid),
        .word       (asm_word)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        count_d = count_q;
        we_d    = 1'b0;
        mips_d  = mips_q;
        error_d = error_q;
        if (load_start) begin
            state_d = ST_RECEIVE;
            addr_d  = '0;
            count_d = '0;
            mips_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                ST_RECEIVE: begin
                    if (asm_word_valid) begin
                        instr_d = asm_word;
                        we_d    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    count_d = count_q + ADDR_ONE;
                    if (instr_q == HALT_WORD) begin
                        state_d = ST_DONE;
                        mips_d  = 1'b1;
                    end else if (addr_q == ADDR_LAST) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_RECEIVE;
                    end
                end
                default: ;
            endcase
        end
        loading_d = (state_d == ST_RECEIVE) || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            mips_q    <= 1'b0;
            loading_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            mips_q    <= mips_d;
            loading_q <= loading_d;
            error_q   <= error_d;
        end
    end

    assign instruction_to_write = instr_q;
    assign address_to_write     = addr_q;
    assign write_enable         = we_q;
    assign mips_enable          = mips_q;
    assign loading              = loading_q;
    assign load_error           = error_q;
    assign word_count           = count_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_program_loader : directed and random bench with a transaction-level model|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] instruction_to_write;
    logic [31:0] address_to_write;
    logic        write_enable;
    logic        mips_enable;
    logic        loading;
    logic        load_error;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a load session that collects bytes and commits words
    int          m_mode = M_IDLE;
    int          m_nb   = 0;
    logic [31:0] m_acc  = '0;
    logic [31:0] m_instr = '0;
    bit          m_wr   = 0;
    int          m_addr = 0;
    int          m_wc   = 0;
    bit          m_mips = 0;
    bit          m_err  = 0;

    program_loader #(
        .MEM_DEPTH  (DEPTH),
        .HALT_WORD  (HALT),
        .ADDR_WIDTH (32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .load_start           (load_start),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .instruction_to_write (instruction_to_write),
        .address_to_write     (address_to_write),
        .write_enable         (write_enable),
        .mips_enable          (mips_enable),
        .loading              (loading),
        .load_error           (load_error),
        .word_count           (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic ls, input logic v, input logic [7:0] d);
        bit was_load;
        if (!rst_n) begin
            m_mode = M_IDLE; m_nb = 0; m_acc = '0; m_instr = '0; m_wr = 0;
            m_addr = 0; m_wc = 0; m_mips = 0; m_err = 0;
        end else if (ls) begin
            m_mode = M_LOAD; m_nb = 0; m_acc = '0; m_wr = 0;
            m_addr = 0; m_wc = 0; m_mips = 0; m_err = 0;
        end else begin
            was_load = (m_mode == M_LOAD);
            if (m_wr) begin
                m_wr = 0;
                m_wc++;
                if (m_instr == HALT) begin
                    m_mode = M_DONE; m_mips = 1;
                end else if (m_addr == DEPTH - 1) begin
                    m_mode = M_ERR; m_err = 1;
                end else begin
                    m_addr++;
                end
            end
            if (was_load && v) begin
                m_acc = (m_acc << 8) | 32'(d);
                m_nb++;
                if (m_nb == 4) begin
                    m_nb = 0; m_instr = m_acc; m_wr = 1;
                end
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic ls, input logic v, input logic [7:0] d);
        reset = rst_n; load_start = ls; rx_valid = v; rx_data = d;
        @(posedge clk);
        cyc++;
        model_edge(rst_n, ls, v, d);
        #1;
        check("write_enable", 32'(write_enable), 32'(m_wr));
        check("instruction", instruction_to_write, m_instr);
        check("address", address_to_write, 32'(m_addr));
        check("word_count", word_count, 32'(m_wc));
        check("mips_enable", 32'(mips_enable), 32'(m_mips));
        check("loading", 32'(loading), 32'(m_mode == M_LOAD));
        check("load_error", 32'(load_error), 32'(m_err));
        check("we_mips_excl", 32'(write_enable && mips_enable), 32'd0);
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            int gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) step(1, 0, 0, 8'($urandom));
            step(1, 0, 1, w[31-8*i -: 8]);
        end
    endtask

    initial begin
        int          wr_cyc[$];
        logic [31:0] wr_addr[$];
        logic        r_rst, r_ls, r_v;
        logic [7:0]  r_d;

        // Reset and reset mid-load
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h12);
        step(1, 1, 0, 8'h00);
        step(1, 0, 1, 8'h01);
        step(1, 0, 1, 8'h02);
        step(0, 0, 0, 8'h00);
        check("reset_loading", 32'(loading), 32'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 8'($urandom));

        // Basic load
        step(1, 1, 0, 8'h00);
        step(1, 0, 1, 8'h12);
        step(1, 0, 1, 8'h34);
        step(1, 0, 1, 8'h56);
        step(1, 0, 1, 8'h78);
        check("basic_we", 32'(write_enable), 32'd1);
        check("basic_word", instruction_to_write, 32'h1234_5678);
        check("basic_addr", address_to_write, 32'd0);
        send_word(HALT, 1);
        check("halt_addr", address_to_write, 32'd1);
        step(1, 0, 0, 8'h00);
        check("basic_mips", 32'(mips_enable), 32'd1);
        check("basic_wc", word_count, 32'd2);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 8'($urandom));

        // DONE reload, then back-to-back bytes
        step(1, 1, 0, 8'h00);
        check("reload_mips", 32'(mips_enable), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1, 8'($urandom_range(0, 254)));
            if (write_enable) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(address_to_write);
            end
        end
        step(1, 0, 0, 8'h00);
        check("b2b_writes", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) check("b2b_addr", wr_addr[i], 32'(i));
            check("b2b_gap0", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
            check("b2b_gap1", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
        end

        // Restart mid-word and load_start colliding with a byte
        step(1, 1, 0, 8'h00);
        send_word(32'h0102_0304, 0);
        step(1, 0, 1, 8'h05);
        step(1, 0, 1, 8'h06);
        step(1, 0, 1, 8'h07);
        step(1, 1, 0, 8'h00);
        send_word(32'hAABB_CCDD, 0);
        check("restart_word", instruction_to_write, 32'hAABB_CCDD);
        check("restart_addr", address_to_write, 32'd0);
        step(1, 0, 0, 8'h00);
        check("restart_wc", word_count, 32'd1);
        step(1, 1, 1, 8'h11);
        send_word(32'h2233_4455, 0);
        check("collide_word", instruction_to_write, 32'h2233_4455);
        check("collide_addr", address_to_write, 32'd0);

        // Overflow of a 4-word memory
        step(1, 1, 0, 8'h00);
        for (int w = 0; w < 4; w++) send_word(32'h1000_0000 + 32'($urandom_range(0, 65535)), 2);
        step(1, 0, 0, 8'h00);
        check("ovf_error", 32'(load_error), 32'd1);
        check("ovf_mips", 32'(mips_enable), 32'd0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 8'($urandom));
        step(1, 1, 0, 8'h00);
        check("ovf_cleared", 32'(load_error), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            r_rst = (r < 2) ? 1'b0 : 1'b1;
            r_ls  = (r >= 2 && r < 6) ? 1'b1 : 1'b0;
            r_v   = 1'($urandom_range(0, 1));
            r_d   = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            step(r_rst, r_ls, r_v, r_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of instruction_fetch.
- Assembles a serial byte stream (from the UART receiver) into 32-bit instruction words and drives the fetch stage's instruction-memory write port (instruction_to_write, address_to_write, write_enable).
- On receipt of the HALT word, loading ends and mips_enable is raised so the pipeline starts fetching from word address 0.

Parameters:
- MEM_DEPTH, 256, instruction memory depth in words; highest writable address is MEM_DEPTH-1.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory like any other word.
- ADDR_WIDTH, 32, width of address_to_write.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled at posedge clk, asserted when 0.
- load_start  input  1  single-cycle pulse; begins or restarts a load.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data is valid this cycle; one byte per asserted cycle, no backpressure.
- instruction_to_write  output  32  assembled instruction word.
- address_to_write  output  ADDR_WIDTH  word address of instruction_to_write.
- write_enable  output  1  one-cycle write strobe to instruction memory.
- mips_enable  output  1  pipeline run enable.
- loading  output  1  high in RECEIVE or WRITE.
- load_error  output  1  program overflowed MEM_DEPTH.
- word_count  output  ADDR_WIDTH  words written in current or last load.

Behaviour:
- Reset (reset==0 at posedge) forces:
  - state IDLE; all outputs 0; byte counter 0; shift register 0.
  - Reset overrides every other input, including mid-load.
- States: IDLE, RECEIVE, WRITE, DONE, ERROR.
- IDLE:
  - rx_valid ignored.
  - load_start -> RECEIVE; clears address, word_count and byte counter.
- Byte assembly (active in RECEIVE and WRITE):
  - Each rx_valid: shift = {shift[23:0], rx_data}, so the first byte becomes bits 31:24 (big-endian).
  - byte_cnt increments 0..3.
  - On the 4th byte, the complete word is latched into the output register and state -> WRITE on the next edge.
  - byte_cnt wraps to 0.
- Latency: write_enable is high exactly one cycle, the cycle after the posedge that sampled the 4th byte.
  - instruction_to_write and address_to_write are valid and stable in that cycle and held afterwards.
- WRITE (1 cycle):
  - Word == HALT_WORD -> DONE. address_to_write is not incremented; word_count increments.
  - Otherwise, address_to_write == MEM_DEPTH-1 -> ERROR.
  - Otherwise address_to_write++, word_count++, and state -> RECEIVE.
  - A byte arriving during WRITE is accepted by the assembler; no byte is ever lost.
- DONE:
  - mips_enable=1, held; loading=0.
  - rx_valid ignored.
  - load_start -> mips_enable drops the same edge, then RECEIVE as from IDLE.
- ERROR:
  - load_error=1, mips_enable=0, rx_valid ignored.
  - Exits only via reset (-> IDLE) or load_start (-> RECEIVE, load_error cleared).
- load_start during RECEIVE or WRITE:
  - Restart: partial word discarded; address, byte_cnt and word_count cleared.
  - A pending write strobe is suppressed.
- load_start together with rx_valid in the same cycle: load_start wins and the byte is discarded.
- Address wrap-around never occurs; reaching MEM_DEPTH-1 without HALT is an error.
- mips_enable and write_enable are never high in the same cycle.

Decomposition:
- Shared package (mips_pkg):
  - loader state encoding (3-bit enum/localparams).
  - HALT_WORD default.
  - BYTE_WIDTH=8, WORD_BYTES=4.
  - Instruction and address width constants shared with instruction_fetch.
- Sub-module byte_assembler (8-to-32 shift register plus 2-bit counter, clear input, word_valid pulse out).
- The FSM lives in program_loader.

Test Plan:
- Reset mid-load: hold reset=0 after 2 bytes -> all outputs 0, state IDLE; following bytes without load_start produce no write.
- Basic load:
  - Stimulus: load_start, then bytes 12 34 56 78.
  - Response: write_enable for one cycle with instruction_to_write=0x12345678, address_to_write=0.
  - Stimulus: continue with bytes FF FF FF FF.
  - Response: write of 0xFFFFFFFF at address 1, then mips_enable=1, word_count=2.
- Back-to-back bytes:
  - Stimulus: rx_valid held high for 12 consecutive cycles.
  - Response: three writes at addresses 0,1,2, each exactly 4 cycles apart; no byte dropped during WRITE.
- Restart:
  - Stimulus: load_start after 3 bytes of word 1, then AA BB CC DD.
  - Response: write 0xAABBCCDD at address 0, word_count=1.
  - Stimulus: load_start together with rx_valid.
  - Response: that byte is discarded.
- Overflow with MEM_DEPTH=4:
  - Stimulus: 4 non-HALT words.
  - Response: writes at 0..3, then load_error=1, mips_enable=0; further bytes ignored until load_start.
- DONE reload: after a completed load, load_start -> mips_enable falls on the next edge and a new load starts at address 0.
